// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   Architectural integer register file with per-register rename tags.
//   It sits between instruction issue and the reorder buffer's commit port.
//   Commits write values and release renames when the commit's ROB tag still
//   matches the register's current tag. Issues mark the destination register
//   busy with the allocated ROB tag. A clear drops all pending renames.
//   The two read ports are combinational and forward a same-cycle commit.
//
// Ports
//   clk_in, rst_in        clock, synchronous active-high reset
//   rdy_in                when low, all state holds and forwarding is off
//   clear_signal          misprediction flush: all busy bits drop, issue ignored
//   issue_signal          issue valid; issue_rd_id / issue_tag give the rename
//   reg_done              commit valid; reg_value / reg_id / reg_tag
//   rs1_id, rs2_id        source register ids
//   rsN_value/busy/tag    ready value, or the ROB tag to wait on when busy
// -----------------------------------------------------------------------------
module register_file #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clear_signal,
  input  logic                 issue_signal,
  input  logic [4:0]           issue_rd_id,
  input  logic [ROB_WIDTH-1:0] issue_tag,
  input  logic                 reg_done,
  input  logic [31:0]          reg_value,
  input  logic [4:0]           reg_id,
  input  logic [ROB_WIDTH-1:0] reg_tag,
  input  logic [4:0]           rs1_id,
  input  logic [4:0]           rs2_id,
  output logic [31:0]          rs1_value,
  output logic [31:0]          rs2_value,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [ROB_WIDTH-1:0] rs1_tag,
  output logic [ROB_WIDTH-1:0] rs2_tag
);

  // Entry 0 is never written after reset, so it stays constant zero.
  logic [31:0]          value_reg [0:31];
  logic [ROB_WIDTH-1:0] tag_reg   [0:31];
  logic [31:0]          busy_reg;

  logic [31:0] commit_hit;
  logic [31:0] issue_hit;
  logic [31:0] release_hit;
  logic        flush;

  assign flush = rdy_in & clear_signal;

  assign commit_hit[0]  = 1'b0;
  assign issue_hit[0]   = 1'b0;
  assign release_hit[0] = 1'b0;

  // Per-register decode of commit and issue.
  // A commit only releases the rename if the register still waits on that
  // exact ROB entry; a later issue to the same register makes it stale.
  genvar gi;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_decode
      localparam logic [4:0] IDX = 5'(gi);
      assign commit_hit[gi]  = rdy_in & reg_done & (reg_id == IDX);
      assign release_hit[gi] = commit_hit[gi] & busy_reg[gi] & (tag_reg[gi] == reg_tag);
      assign issue_hit[gi]   = rdy_in & issue_signal & ~clear_signal & (issue_rd_id == IDX);
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        value_reg[i] <= '0;
        tag_reg[i]   <= '0;
      end
      busy_reg <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        // Commits arrive in program order, so the value is always written.
        if (commit_hit[i]) value_reg[i] <= reg_value;
        if (issue_hit[i])  tag_reg[i]   <= issue_tag;
      end
      // Set after clear: a same-cycle issue to the committing register wins.
      if (flush) busy_reg <= '0;
      else       busy_reg <= (busy_reg & ~release_hit) | issue_hit;
    end
  end

  // Read ports. They see pre-issue state, so an instruction that reads and
  // writes the same register gets the old mapping.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read
      logic [4:0]           id;
      logic                 fwd;
      logic [31:0]          val;
      logic                 busy;
      logic [ROB_WIDTH-1:0] tag;

      assign id  = (gi == 0) ? rs1_id : rs2_id;
      assign fwd = busy_reg[id] & rdy_in & reg_done & (reg_id == id) & (reg_tag == tag_reg[id]);

      always_comb begin
        val  = value_reg[id];
        busy = busy_reg[id];
        tag  = tag_reg[id];
        if (id == 5'd0) begin
          val  = '0;
          busy = 1'b0;
          tag  = '0;
        end else if (fwd) begin
          val  = reg_value;
          busy = 1'b0;
        end
      end
    end
  endgenerate

  assign rs1_value = g_read[0].val;
  assign rs1_busy  = g_read[0].busy;
  assign rs1_tag   = g_read[0].tag;
  assign rs2_value = g_read[1].val;
  assign rs2_busy  = g_read[1].busy;
  assign rs2_tag   = g_read[1].tag;

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Self-checking bench for register_file: directed scenarios with fixed
//   expected values, then randomized traffic checked against an array model.
// -----------------------------------------------------------------------------
module tb_register_file;
  localparam int RW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clear_signal, issue_signal, reg_done;
  logic [4:0]    issue_rd_id, reg_id, rs1_id, rs2_id;
  logic [RW-1:0] issue_tag, reg_tag, rs1_tag, rs2_tag;
  logic [31:0]   reg_value, rs1_value, rs2_value;
  logic          rs1_busy, rs2_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural state per register.
  logic [31:0]   m_val  [32];
  logic          m_busy [32];
  logic [RW-1:0] m_tag  [32];

  register_file #(.ROB_WIDTH(RW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_signal(clear_signal),
    .issue_signal(issue_signal), .issue_rd_id(issue_rd_id), .issue_tag(issue_tag),
    .reg_done(reg_done), .reg_value(reg_value), .reg_id(reg_id), .reg_tag(reg_tag),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
  );

  always #5 clk_in = ~clk_in;

  // Apply the rules to the model using the inputs present at the clock edge.
  task automatic model_update();
    bit rel;
    rel = 1'b0;
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0;
      end
    end else if (rdy_in) begin
      if (reg_done && reg_id != 0) begin
        m_val[reg_id] = reg_value;
        rel = m_busy[reg_id] && (m_tag[reg_id] == reg_tag);
      end
      if (clear_signal) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 0;
      end else begin
        if (rel) m_busy[reg_id] = 0;
        if (issue_signal && issue_rd_id != 0) begin
          m_busy[issue_rd_id] = 1;
          m_tag[issue_rd_id]  = issue_tag;
        end
      end
    end
  endtask

  function automatic void exp_read(input logic [4:0] id, output logic [31:0] v,
                                   output logic b, output logic [RW-1:0] t);
    if (id == 0) begin
      v = 0; b = 0; t = 0;
    end else if (m_busy[id] && rdy_in && reg_done && reg_id == id && reg_tag == m_tag[id]) begin
      v = reg_value; b = 0; t = m_tag[id];
    end else begin
      v = m_val[id]; b = m_busy[id]; t = m_tag[id];
    end
  endfunction

  task automatic tick();
    @(posedge clk_in);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst_in = 0; rdy_in = 1; clear_signal = 0;
    issue_signal = 0; issue_rd_id = 0; issue_tag = 0;
    reg_done = 0; reg_value = 0; reg_id = 0; reg_tag = 0;
    rs1_id = 0; rs2_id = 0;
  endtask

  task automatic test_reset();
    idle(); rst_in = 1;
    tick(); tick();
    idle(); rs1_id = 5; rs2_id = 0;
    @(negedge clk_in);
    $display("reset: rs1=%h/%0b rs2=%h/%0b", rs1_value, rs1_busy, rs2_value, rs2_busy);
    n_checks++; if (rs1_value !== 32'h0) begin n_fail++; $display("FAIL reset_rs1_value: got %h want 0", rs1_value); end
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rs1_busy: got %0b want 0", rs1_busy); end
    n_checks++; if (rs2_value !== 32'h0) begin n_fail++; $display("FAIL reset_rs2_value: got %h want 0", rs2_value); end
    n_checks++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL reset_rs2_busy: got %0b want 0", rs2_busy); end
    // Paused: issue and commit must both be ignored for three cycles.
    rdy_in = 0; issue_signal = 1; issue_rd_id = 5; issue_tag = 3;
    reg_done = 1; reg_id = 5; reg_value = 32'hDEAD; reg_tag = 3;
    tick(); tick(); tick();
    idle(); rs1_id = 5;
    @(negedge clk_in);
    $display("pause: rs1=%h/%0b", rs1_value, rs1_busy);
    n_checks++; if (rs1_value !== 32'h0) begin n_fail++; $display("FAIL pause_value: got %h want 0", rs1_value); end
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL pause_busy: got %0b want 0", rs1_busy); end
  endtask

  task automatic test_rename_commit();
    idle(); issue_signal = 1; issue_rd_id = 5; issue_tag = 3;
    tick();
    idle(); rs1_id = 5;
    @(negedge clk_in);
    $display("rename: rs1 busy=%0b tag=%0d", rs1_busy, rs1_tag);
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL rename_busy: got %0b want 1", rs1_busy); end
    n_checks++; if (rs1_tag !== 4'd3) begin n_fail++; $display("FAIL rename_tag: got %0d want 3", rs1_tag); end
    reg_done = 1; reg_id = 5; reg_tag = 3; reg_value = 32'h1234;
    @(negedge clk_in);
    $display("forward: rs1=%h/%0b", rs1_value, rs1_busy);
    n_checks++; if (rs1_value !== 32'h1234) begin n_fail++; $display("FAIL fwd_value: got %h want 1234", rs1_value); end
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL fwd_busy: got %0b want 0", rs1_busy); end
    tick();
    idle(); rs1_id = 5;
    @(negedge clk_in);
    $display("stored: rs1=%h/%0b", rs1_value, rs1_busy);
    n_checks++; if (rs1_value !== 32'h1234) begin n_fail++; $display("FAIL stored_value: got %h want 1234", rs1_value); end
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL stored_busy: got %0b want 0", rs1_busy); end
  endtask

  task automatic test_stale_commit();
    idle(); issue_signal = 1; issue_rd_id = 5; issue_tag = 3; tick();
    idle(); issue_signal = 1; issue_rd_id = 5; issue_tag = 7; tick();
    idle(); reg_done = 1; reg_id = 5; reg_tag = 3; reg_value = 32'hAA; rs1_id = 5;
    @(negedge clk_in);
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL stale_nofwd_busy: got %0b want 1", rs1_busy); end
    tick();
    idle(); rs1_id = 5;
    @(negedge clk_in);
    $display("stale: rs1=%h/%0b tag=%0d", rs1_value, rs1_busy, rs1_tag);
    n_checks++; if (rs1_value !== 32'hAA) begin n_fail++; $display("FAIL stale_value: got %h want aa", rs1_value); end
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL stale_busy: got %0b want 1", rs1_busy); end
    n_checks++; if (rs1_tag !== 4'd7) begin n_fail++; $display("FAIL stale_tag: got %0d want 7", rs1_tag); end
    reg_done = 1; reg_id = 5; reg_tag = 7; reg_value = 32'hBB; tick();
    idle(); rs1_id = 5;
    @(negedge clk_in);
    $display("current: rs1=%h/%0b", rs1_value, rs1_busy);
    n_checks++; if (rs1_value !== 32'hBB) begin n_fail++; $display("FAIL current_value: got %h want bb", rs1_value); end
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL current_busy: got %0b want 0", rs1_busy); end
  endtask

  task automatic test_collision();
    idle(); issue_signal = 1; issue_rd_id = 6; issue_tag = 1; tick();
    idle(); reg_done = 1; reg_id = 6; reg_tag = 1; reg_value = 32'h55;
    issue_signal = 1; issue_rd_id = 6; issue_tag = 2; tick();
    idle(); rs2_id = 6;
    @(negedge clk_in);
    $display("collision: rs2=%h/%0b tag=%0d", rs2_value, rs2_busy, rs2_tag);
    n_checks++; if (rs2_value !== 32'h55) begin n_fail++; $display("FAIL coll_value: got %h want 55", rs2_value); end
    n_checks++; if (rs2_busy !== 1'b1) begin n_fail++; $display("FAIL coll_busy: got %0b want 1", rs2_busy); end
    n_checks++; if (rs2_tag !== 4'd2) begin n_fail++; $display("FAIL coll_tag: got %0d want 2", rs2_tag); end
  endtask

  task automatic test_x0();
    idle(); issue_signal = 1; issue_rd_id = 0; issue_tag = 4; tick();
    idle(); reg_done = 1; reg_id = 0; reg_tag = 0; reg_value = 32'hFFFFFFFF; rs1_id = 0;
    @(negedge clk_in);
    n_checks++; if (rs1_value !== 32'h0) begin n_fail++; $display("FAIL x0_fwd_value: got %h want 0", rs1_value); end
    tick();
    idle(); rs1_id = 0;
    @(negedge clk_in);
    $display("x0: rs1=%h/%0b", rs1_value, rs1_busy);
    n_checks++; if (rs1_value !== 32'h0) begin n_fail++; $display("FAIL x0_value: got %h want 0", rs1_value); end
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL x0_busy: got %0b want 0", rs1_busy); end
  endtask

  task automatic test_flush();
    idle(); issue_signal = 1; issue_rd_id = 3; issue_tag = 2; tick();
    idle(); issue_signal = 1; issue_rd_id = 9; issue_tag = 5; tick();
    idle(); reg_done = 1; reg_id = 9; reg_tag = 0; reg_value = 32'h77; tick();
    idle(); clear_signal = 1; issue_signal = 1; issue_rd_id = 10; issue_tag = 6; tick();
    idle(); rs1_id = 3; rs2_id = 9;
    @(negedge clk_in);
    $display("flush: x3 busy=%0b x9=%h/%0b", rs1_busy, rs2_value, rs2_busy);
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL flush_x3_busy: got %0b want 0", rs1_busy); end
    n_checks++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL flush_x9_busy: got %0b want 0", rs2_busy); end
    n_checks++; if (rs2_value !== 32'h77) begin n_fail++; $display("FAIL flush_x9_value: got %h want 77", rs2_value); end
    rs1_id = 10; #1;
    n_checks++; if (rs1_busy !== 1'b0) begin n_fail++; $display("FAIL flush_x10_busy: got %0b want 0", rs1_busy); end
    // Same clear while paused must do nothing.
    idle(); issue_signal = 1; issue_rd_id = 3; issue_tag = 2; tick();
    idle(); rdy_in = 0; clear_signal = 1; issue_signal = 1; issue_rd_id = 10; issue_tag = 6; tick();
    idle(); rs1_id = 3; rs2_id = 10;
    @(negedge clk_in);
    $display("paused flush: x3 busy=%0b tag=%0d x10 busy=%0b", rs1_busy, rs1_tag, rs2_busy);
    n_checks++; if (rs1_busy !== 1'b1) begin n_fail++; $display("FAIL pflush_x3_busy: got %0b want 1", rs1_busy); end
    n_checks++; if (rs1_tag !== 4'd2) begin n_fail++; $display("FAIL pflush_x3_tag: got %0d want 2", rs1_tag); end
    n_checks++; if (rs2_busy !== 1'b0) begin n_fail++; $display("FAIL pflush_x10_busy: got %0b want 0", rs2_busy); end
  endtask

  task automatic test_random();
    logic [31:0]   ev1, ev2;
    logic          eb1, eb2;
    logic [RW-1:0] et1, et2;
    for (int n = 0; n < 300; n++) begin
      idle();
      rdy_in       = ($urandom_range(0, 7) != 0);
      clear_signal = ($urandom_range(0, 19) == 0);
      issue_signal = $urandom_range(0, 1);
      issue_rd_id  = 5'($urandom_range(0, 7));
      issue_tag    = RW'($urandom);
      reg_done     = $urandom_range(0, 1);
      reg_id       = 5'($urandom_range(0, 7));
      reg_value    = $urandom;
      reg_tag      = ($urandom_range(0, 1) != 0) ? m_tag[reg_id] : RW'($urandom);
      rs1_id       = ($urandom_range(0, 1) != 0) ? reg_id : 5'($urandom_range(0, 7));
      rs2_id       = 5'($urandom_range(0, 31));
      @(negedge clk_in);
      exp_read(rs1_id, ev1, eb1, et1);
      exp_read(rs2_id, ev2, eb2, et2);
      $display("txn %0d rdy=%0b clr=%0b iss=%0b/%0d/%0d done=%0b/%0d/%0d rs1=%0d:%h/%0b rs2=%0d:%h/%0b",
               n, rdy_in, clear_signal, issue_signal, issue_rd_id, issue_tag, reg_done, reg_id, reg_tag,
               rs1_id, rs1_value, rs1_busy, rs2_id, rs2_value, rs2_busy);
      n_checks++; if (rs1_value !== ev1) begin n_fail++; $display("FAIL rnd_rs1_value txn %0d: got %h want %h", n, rs1_value, ev1); end
      n_checks++; if (rs1_busy !== eb1) begin n_fail++; $display("FAIL rnd_rs1_busy txn %0d: got %0b want %0b", n, rs1_busy, eb1); end
      n_checks++; if (rs2_value !== ev2) begin n_fail++; $display("FAIL rnd_rs2_value txn %0d: got %h want %h", n, rs2_value, ev2); end
      n_checks++; if (rs2_busy !== eb2) begin n_fail++; $display("FAIL rnd_rs2_busy txn %0d: got %0b want %0b", n, rs2_busy, eb2); end
      if (eb1) begin
        n_checks++; if (rs1_tag !== et1) begin n_fail++; $display("FAIL rnd_rs1_tag txn %0d: got %0d want %0d", n, rs1_tag, et1); end
      end
      if (eb2) begin
        n_checks++; if (rs2_tag !== et2) begin n_fail++; $display("FAIL rnd_rs2_tag txn %0d: got %0d want %0d", n, rs2_tag, et2); end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rename_commit();
    test_stale_commit();
    test_collision();
    test_x0();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
